flp_adder_align: RTL and testbench



---
 rtl/flp_adder_align.sv | 103 ++++++++++
 tb/tb_flp_adder_align.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/flp_adder_align.sv
// flp_adder_align: front half of the pipelined FP adder; swaps so b is the larger operand and aligns a.
// Denormal handling is enabled with FLP_ALIGN_DENORM_EN; otherwise exponent-0 operands are flushed to zero.
`ifdef SINGLE_PRECISION
`undef EXPONENT_BITS
`undef SIGNIFICANT_BITS
`undef OVERALL_BITS
`define EXPONENT_BITS 8
`define SIGNIFICANT_BITS 23
`endif
`ifndef EXPONENT_BITS
`define EXPONENT_BITS 8
`endif
`ifndef SIGNIFICANT_BITS
`define SIGNIFICANT_BITS 23
`endif
`ifndef OVERALL_BITS
`define OVERALL_BITS (1 + `EXPONENT_BITS + `SIGNIFICANT_BITS)
`endif
module flp_adder_align (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         data_valid,
   input  logic [`OVERALL_BITS-1:0]     operand_a,
   input  logic [`OVERALL_BITS-1:0]     operand_b,
   input  logic                         subtract,
   output logic                         data_valid_2DP,
   output logic                         sign_result_2DP,
   output logic                         signs_equal_2DP,
   output logic                         bit_shifted_out_2DP,
   output logic                         denorm_underflow_2DP,
   output logic [`EXPONENT_BITS-1:0]    exponent_b_2DP,
   output logic [`SIGNIFICANT_BITS:0]   significant_b_2DP,
   output logic [`SIGNIFICANT_BITS:0]   denorm_significant_a_2DP
);
   localparam int E = `EXPONENT_BITS;
   localparam int S = `SIGNIFICANT_BITS;
   logic         sign_a, sign_b, swap;
   logic [E-1:0] exp_a, exp_b, eff_a, eff_b;
   logic [S-1:0] frac_a, frac_b;
   logic         v1, sign1, eq1;
   logic [E-1:0] exp1, diff1;
   logic [S:0]   sig_b1, sig_a1;
   logic [S+1:0] ext;
   logic         uf;
   assign sign_a = operand_a[S+E];
   assign sign_b = operand_b[S+E] ^ subtract;
   assign exp_a  = operand_a[S+:E];
   assign exp_b  = operand_b[S+:E];
`ifdef FLP_ALIGN_DENORM_EN
   assign frac_a = operand_a[S-1:0];
   assign frac_b = operand_b[S-1:0];
`else
   assign frac_a = exp_a == '0 ? '0 : operand_a[S-1:0];
   assign frac_b = exp_b == '0 ? '0 : operand_b[S-1:0];
`endif
   assign eff_a = exp_a == '0 ? E'(1) : exp_a;
   assign eff_b = exp_b == '0 ? E'(1) : exp_b;
   // ties send operand_a to the b slot
   assign swap  = {exp_a, frac_a} >= {exp_b, frac_b};
   // the extra low bit catches the guard bit, and is zero when no shift happens
   assign ext = {sig_a1, 1'b0} >> diff1;
`ifdef FLP_ALIGN_DENORM_EN
   assign uf = 32'(diff1) >= S + 1;
`else
   // a flushed zero has nothing to shift out
   assign uf = 32'(diff1) >= S + 1 && sig_a1 != '0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1                       <= 1'b0;
         sign1                    <= 1'b0;
         eq1                      <= 1'b0;
         exp1                     <= '0;
         diff1                    <= '0;
         sig_b1                   <= '0;
         sig_a1                   <= '0;
         data_valid_2DP           <= 1'b0;
         sign_result_2DP          <= 1'b0;
         signs_equal_2DP          <= 1'b0;
         bit_shifted_out_2DP      <= 1'b0;
         denorm_underflow_2DP     <= 1'b0;
         exponent_b_2DP           <= '0;
         significant_b_2DP        <= '0;
         denorm_significant_a_2DP <= '0;
      end else begin
         v1                       <= data_valid;
         sign1                    <= swap ? sign_a : sign_b;
         eq1                      <= sign_a == sign_b;
         exp1                     <= swap ? exp_a : exp_b;
         diff1                    <= swap ? eff_a - eff_b : eff_b - eff_a;
         sig_b1                   <= swap ? {exp_a != '0, frac_a} : {exp_b != '0, frac_b};
         sig_a1                   <= swap ? {exp_b != '0, frac_b} : {exp_a != '0, frac_a};
         data_valid_2DP           <= v1;
         sign_result_2DP          <= sign1;
         signs_equal_2DP          <= eq1;
         bit_shifted_out_2DP      <= !uf && ext[0];
         denorm_underflow_2DP     <= uf;
         exponent_b_2DP           <= exp1;
         significant_b_2DP        <= sig_b1;
         denorm_significant_a_2DP <= uf ? '0 : ext[S+1:1];
      end
   end
endmodule

// File: tb/tb_flp_adder_align.sv
// tb_flp_adder_align: scoreboard bench for the single-precision alignment stage.
// Expected values come from a behavioural model pushed at drive time and popped at output.
module tb_flp_adder_align;
   typedef struct {
      logic [59:0] v;
      int          c;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        data_valid = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        subtract = 1'b0;
   logic        data_valid_2DP, sign_result_2DP, signs_equal_2DP;
   logic        bit_shifted_out_2DP, denorm_underflow_2DP;
   logic [7:0]  exponent_b_2DP;
   logic [23:0] significant_b_2DP, denorm_significant_a_2DP;
   logic [59:0] got;
   exp_t        q[$];
   int          n_vec = 0, n_miss = 0, cyc = 0;
   flp_adder_align dut (
      .clk(clk), .rst(rst), .data_valid(data_valid),
      .operand_a(operand_a), .operand_b(operand_b), .subtract(subtract),
      .data_valid_2DP(data_valid_2DP), .sign_result_2DP(sign_result_2DP),
      .signs_equal_2DP(signs_equal_2DP), .bit_shifted_out_2DP(bit_shifted_out_2DP),
      .denorm_underflow_2DP(denorm_underflow_2DP), .exponent_b_2DP(exponent_b_2DP),
      .significant_b_2DP(significant_b_2DP), .denorm_significant_a_2DP(denorm_significant_a_2DP)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign got = {sign_result_2DP, signs_equal_2DP, bit_shifted_out_2DP, denorm_underflow_2DP,
                 exponent_b_2DP, significant_b_2DP, denorm_significant_a_2DP};
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      if (obs !== want) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask
   function automatic logic [59:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      logic        sa, sb, s_big, uf, g;
      logic [7:0]  ea, eb, e_big, e_small;
      logic [22:0] fa, fb, f_big, f_small;
      logic [23:0] sig_small, den;
      int          d;
      sa = a[31]; ea = a[30:23]; fa = a[22:0];
      sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
`ifndef FLP_ALIGN_DENORM_EN
      if (ea == 0) fa = 0;
      if (eb == 0) fb = 0;
`endif
      if ({ea, fa} >= {eb, fb}) begin
         s_big = sa; e_big = ea; f_big = fa; e_small = eb; f_small = fb;
      end else begin
         s_big = sb; e_big = eb; f_big = fb; e_small = ea; f_small = fa;
      end
      sig_small = {e_small != 0, f_small};
      d = (e_big == 0 ? 1 : int'(e_big)) - (e_small == 0 ? 1 : int'(e_small));
      if (d >= 24) begin
`ifdef FLP_ALIGN_DENORM_EN
         uf = 1'b1;
`else
         uf = sig_small != 0;
`endif
         den = 0; g = 0;
      end else begin
         uf = 1'b0;
         den = sig_small >> d;
         g = d > 0 ? sig_small[d-1] : 1'b0;
      end
      return {s_big, sa == sb, g, uf, e_big, e_big != 0, f_big, den};
   endfunction
   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic sub);
      exp_t e;
      @(posedge clk); #1;
      data_valid = 1'b1; operand_a = a; operand_b = b; subtract = sub;
      e.v = model(a, b, sub); e.c = cyc;
      q.push_back(e);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         data_valid = 1'b0;
         operand_a = $urandom; operand_b = $urandom; subtract = 1'(($urandom));
      end
   endtask
   always @(negedge clk) begin
      if (!rst && data_valid_2DP) begin
         if (q.size() == 0) check("unexpected_valid", 64'(data_valid_2DP), 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("result", 64'(got), 64'(e.v));
            check("latency", 64'(cyc - e.c), 64'd2);
         end
      end
   end
   initial begin
      repeat (2) @(posedge clk);
      #1 check("reset_state", 64'({data_valid_2DP, got}), 64'd0);
      rst = 1'b0;
      idle(2);
      apply(32'h3F800000, 32'h40000000, 1'b0);
      apply(32'h3F800001, 32'h40000000, 1'b0);
      apply(32'hBFC00000, 32'h40000000, 1'b0);
      apply(32'h3F800000, 32'h4E800000, 1'b0);
      apply(32'h3F800000, 32'h3F800000, 1'b1);
      apply(32'h00000001, 32'h3F800000, 1'b0);
      apply(32'h3FC00000, 32'h4B000000, 1'b0);
      apply(32'h4B800000, 32'h3F800000, 1'b1);
      apply(32'h00000000, 32'h80000000, 1'b0);
      idle(4);
      check("known_1p0_plus_2p0", 64'(model(32'h3F800000, 32'h40000000, 1'b0)),
            64'({1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 24'h800000, 24'h400000}));
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom;
         if (i % 3 == 0) b[30:23] = a[30:23] + 8'($urandom_range(0, 3));
         if (i % 5 == 0) a[30:23] = 8'd0;
         apply(a, b, 1'(i));
      end
      idle(4);
      apply(32'h40400000, 32'h3F000000, 1'b0);
      apply(32'hC0800000, 32'h41000000, 1'b1);
      @(posedge clk); #1;
      data_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1 check("async_reset_clear", 64'({data_valid_2DP, got}), 64'd0);
      q.delete();
      idle(2);
      rst = 1'b0;
      idle(6);
      apply(32'h3F800000, 32'h40000000, 1'b0);
      idle(2);
      repeat (10) @(posedge clk);
      #1 check("drain", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
